// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared encodings for the load/store data port
package lsu_pkg;

    // Access size encodings on req_size
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    // Response codes on rsp_err
    localparam logic [1:0] ERR_OK  = 2'd0;
    localparam logic [1:0] ERR_MIS = 2'd1;
    localparam logic [1:0] ERR_BUS = 2'd2;
    localparam logic [1:0] ERR_TMO = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } lsu_state_t;

    // Access size in bytes (1, 2, 4 or 8)
    function automatic logic [3:0] size_bytes(input logic [1:0] size);
        return 4'd1 << size;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - byte-lane steering, load extension and alignment check
module lsu_lane_align
    import lsu_pkg::*;
#(
    parameter  int XLEN  = 32,
    localparam int NB    = XLEN / 8,
    localparam int OFS_W = $clog2(NB)
) (
    input  logic [OFS_W-1:0] i_ofs,
    input  logic [1:0]       i_size,
    input  logic             i_unsigned,
    input  logic [XLEN-1:0]  i_wdata,
    input  logic [XLEN-1:0]  i_rdata,
    output logic [NB-1:0]    o_sel,
    output logic [XLEN-1:0]  o_wdata,
    output logic [XLEN-1:0]  o_rdata,
    output logic             o_misaligned
);

    logic [3:0]       w_nbytes;
    logic [OFS_W-1:0] w_align_mask;
    logic [XLEN-1:0]  w_raw;
    logic [XLEN-1:0]  w_keep;
    logic             w_sign;

    assign w_nbytes     = size_bytes(i_size);
    assign w_align_mask = OFS_W'(w_nbytes - 4'd1);

    // A double access cannot exist on a 32-bit port, so it is folded into the misaligned flag
    assign o_misaligned = ((i_ofs & w_align_mask) != '0) || ((i_size == SZ_D) && (XLEN == 32));

    assign o_wdata = i_wdata << {i_ofs, 3'b000};
    assign w_raw   = i_rdata >> {i_ofs, 3'b000};

    // Byte enables: a run of nbytes ones starting at the byte offset
    always_comb begin
        o_sel = '0;
        for (int i = 0; i < NB; i++) begin
            o_sel[i] = (5'(i) >= 5'(i_ofs)) && (5'(i) < (5'(i_ofs) + 5'(w_nbytes)));
        end
    end

    // Keep mask covering the low nbytes of the right-justified load data
    always_comb begin
        w_keep = '0;
        for (int i = 0; i < NB; i++) begin
            w_keep[8*i +: 8] = {8{4'(i) < w_nbytes}};
        end
    end

    // Sign bit is the top bit of the truncated value; a full-width access needs no extension
    always_comb begin
        w_sign = 1'b0;
        case (i_size)
            SZ_B:    w_sign = w_raw[7];
            SZ_H:    w_sign = w_raw[15];
            SZ_W:    w_sign = w_raw[31];
            default: w_sign = 1'b0;
        endcase
        w_sign = w_sign && !i_unsigned;
    end

    assign o_rdata = (w_raw & w_keep) | (w_sign ? ~w_keep : '0);

endmodule

// File: rtl/lsu_data_port.sv
// rtl/lsu_data_port.sv - single-outstanding load/store engine on a Wishbone-classic bus
module lsu_data_port
    import lsu_pkg::*;
#(
    parameter  int XLEN    = 32,
    parameter  int ADDR_W  = 32,
    parameter  int TIMEOUT = 64,
    localparam int NB      = XLEN / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic              kill,
    output logic              rsp_valid,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic [1:0]        rsp_err,
    output logic [ADDR_W-1:0] wb_adr_o,
    output logic [XLEN-1:0]   wb_dat_o,
    output logic [NB-1:0]     wb_sel_o,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    input  logic [XLEN-1:0]   wb_dat_i,
    input  logic              wb_ack_i,
    input  logic              wb_err_i
);

    localparam int OFS_W = $clog2(NB);
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    lsu_state_t        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [OFS_W-1:0]  r_ofs;
    logic [1:0]        r_size;
    logic              r_uns;
    logic              r_we;
    logic [1:0]        r_err;
    logic [XLEN-1:0]   r_cap;
    logic              r_rsp_valid;
    logic [XLEN-1:0]   r_rsp_rdata;
    logic [1:0]        r_rsp_err;
    logic [ADDR_W-1:0] r_wb_adr;
    logic [XLEN-1:0]   r_wb_dat;
    logic [NB-1:0]     r_wb_sel;
    logic              r_wb_cyc;
    logic              r_wb_stb;
    logic              r_wb_we;

    logic              w_accept;
    logic [OFS_W-1:0]  w_ofs;
    logic [1:0]        w_size;
    logic              w_uns;
    logic [NB-1:0]     w_sel;
    logic [XLEN-1:0]   w_wdata_sh;
    logic [XLEN-1:0]   w_rdata_ext;
    logic              w_mis;
    logic [ADDR_W-1:0] w_adr_aligned;

    assign req_ready = (r_state == ST_IDLE) && rst;
    assign w_accept  = req_valid && req_ready;

    // The lane aligner looks at the live request while idle and at the latched one during the bus cycle
    assign w_ofs  = (r_state == ST_IDLE) ? req_addr[OFS_W-1:0] : r_ofs;
    assign w_size = (r_state == ST_IDLE) ? req_size : r_size;
    assign w_uns  = (r_state == ST_IDLE) ? req_unsigned : r_uns;

    assign w_adr_aligned = {req_addr[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};

    lsu_lane_align #(
        .XLEN(XLEN)
    ) u_lane_align (
        .i_ofs        (w_ofs),
        .i_size       (w_size),
        .i_unsigned   (w_uns),
        .i_wdata      (req_wdata),
        .i_rdata      (wb_dat_i),
        .o_sel        (w_sel),
        .o_wdata      (w_wdata_sh),
        .o_rdata      (w_rdata_ext),
        .o_misaligned (w_mis)
    );

    // Request/bus/response sequencer with all bus and response outputs registered
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_ofs       <= '0;
            r_size      <= SZ_B;
            r_uns       <= 1'b0;
            r_we        <= 1'b0;
            r_err       <= ERR_OK;
            r_cap       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= ERR_OK;
            r_wb_adr    <= '0;
            r_wb_dat    <= '0;
            r_wb_sel    <= '0;
            r_wb_cyc    <= 1'b0;
            r_wb_stb    <= 1'b0;
            r_wb_we     <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_ofs  <= req_addr[OFS_W-1:0];
                        r_size <= req_size;
                        r_uns  <= req_unsigned;
                        r_we   <= req_we;
                        if (w_mis) begin
                            r_err   <= ERR_MIS;
                            r_cap   <= '0;
                            r_state <= ST_RESP;
                        end else begin
                            r_wb_adr <= w_adr_aligned;
                            r_wb_dat <= w_wdata_sh;
                            r_wb_sel <= w_sel;
                            r_wb_we  <= req_we;
                            r_wb_cyc <= 1'b1;
                            r_wb_stb <= 1'b1;
                            r_cnt    <= '0;
                            r_state  <= ST_BUS;
                        end
                    end
                end
                ST_BUS: begin
                    if (kill) begin
                        r_wb_cyc <= 1'b0;
                        r_wb_stb <= 1'b0;
                        r_state  <= ST_IDLE;
                    end else if (wb_ack_i) begin
                        r_wb_cyc <= 1'b0;
                        r_wb_stb <= 1'b0;
                        r_cap    <= r_we ? '0 : w_rdata_ext;
                        r_err    <= ERR_OK;
                        r_state  <= ST_RESP;
                    end else if (wb_err_i) begin
                        r_wb_cyc <= 1'b0;
                        r_wb_stb <= 1'b0;
                        r_cap    <= '0;
                        r_err    <= ERR_BUS;
                        r_state  <= ST_RESP;
                    end else if (r_cnt == CNT_LAST) begin
                        r_wb_cyc <= 1'b0;
                        r_wb_stb <= 1'b0;
                        r_cap    <= '0;
                        r_err    <= ERR_TMO;
                        r_state  <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (!kill) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= r_cap;
                        r_rsp_err   <= r_err;
                    end
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign wb_adr_o  = r_wb_adr;
    assign wb_dat_o  = r_wb_dat;
    assign wb_sel_o  = r_wb_sel;
    assign wb_cyc_o  = r_wb_cyc;
    assign wb_stb_o  = r_wb_stb;
    assign wb_we_o   = r_wb_we;

endmodule

// File: tb/tb_lsu_data_port.sv
// tb/tb_lsu_data_port.sv - self-checking bench for lsu_data_port
module tb_lsu_data_port;

    localparam int T       = 8;
    localparam int M_ACK   = 0;
    localparam int M_ERR   = 1;
    localparam int M_BOTH  = 2;
    localparam int M_TMO   = 3;
    localparam int M_KBUS  = 4;
    localparam int M_KRESP = 5;
    localparam int NONE    = -1000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        req_valid, req_ready, req_we, req_unsigned, kill;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_err;
    logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic        wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i, wb_err_i;

    logic        h_req_valid, h_req_ready, h_req_we, h_req_unsigned, h_kill;
    logic [31:0] h_req_addr;
    logic [63:0] h_req_wdata;
    logic [1:0]  h_req_size;
    logic        h_rsp_valid;
    logic [63:0] h_rsp_rdata;
    logic [1:0]  h_rsp_err;
    logic [31:0] h_wb_adr_o;
    logic [63:0] h_wb_dat_o, h_wb_dat_i;
    logic [7:0]  h_wb_sel_o;
    logic        h_wb_cyc_o, h_wb_stb_o, h_wb_we_o, h_wb_ack_i, h_wb_err_i;

    lsu_data_port #(.XLEN(32), .ADDR_W(32), .TIMEOUT(T)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_we(req_we), .req_size(req_size),
        .req_unsigned(req_unsigned), .kill(kill),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
    );

    lsu_data_port #(.XLEN(64), .ADDR_W(32), .TIMEOUT(T)) dut64 (
        .clk(clk), .rst(rst),
        .req_valid(h_req_valid), .req_ready(h_req_ready), .req_addr(h_req_addr),
        .req_wdata(h_req_wdata), .req_we(h_req_we), .req_size(h_req_size),
        .req_unsigned(h_req_unsigned), .kill(h_kill),
        .rsp_valid(h_rsp_valid), .rsp_rdata(h_rsp_rdata), .rsp_err(h_rsp_err),
        .wb_adr_o(h_wb_adr_o), .wb_dat_o(h_wb_dat_o), .wb_sel_o(h_wb_sel_o),
        .wb_cyc_o(h_wb_cyc_o), .wb_stb_o(h_wb_stb_o), .wb_we_o(h_wb_we_o),
        .wb_dat_i(h_wb_dat_i), .wb_ack_i(h_wb_ack_i), .wb_err_i(h_wb_err_i)
    );

    int checks = 0;
    int failures = 0;
    int cyc_n = 0;

    always @(posedge clk) cyc_n++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h cycle=%0d", name, act, exp, cyc_n);
        end
    endtask

    // Reference model: plain arithmetic on the access rules
    function automatic bit m_mis(input logic [31:0] addr, input logic [1:0] size);
        int n;
        n = 1 << size;
        return (size == 2'd3) || ((int'(addr[1:0]) % n) != 0);
    endfunction

    function automatic logic [3:0] m_sel(input logic [31:0] addr, input logic [1:0] size);
        longint m;
        m = (longint'(1) << (1 << size)) - 1;
        return 4'((m << addr[1:0]) & 15);
    endfunction

    function automatic logic [31:0] m_dat(input logic [31:0] addr, input logic [31:0] wdata);
        return 32'((longint'(wdata) << (8 * addr[1:0])) & 64'hFFFF_FFFF);
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] addr, input logic [1:0] size,
                                           input logic uns, input logic [31:0] bus);
        longint raw, v, span;
        int nbits;
        nbits = 8 * (1 << size);
        span  = longint'(1) << nbits;
        raw   = longint'(bus) >> (8 * addr[1:0]);
        v     = raw & (span - 1);
        if (!uns && (((v >> (nbits - 1)) & 1) == 1)) v = v - span;
        return 32'(v);
    endfunction

    // Expected timeline of the current transaction, in cycle indices
    int          e_a = NONE, e_last = NONE, e_rsp = NONE, e_free = NONE;
    bit          e_bus = 0;
    logic [31:0] e_adr = '0, e_dat = '0, e_rdata = '0;
    logic [3:0]  e_sel = '0;
    logic        e_we = 1'b0;
    logic [1:0]  e_err = '0;
    bit          chk_en = 0;

    logic [31:0] cap_adr, cap_dat, cap_rdata;
    logic [3:0]  cap_sel;
    logic        cap_we;
    logic [1:0]  cap_err;
    int          cap_rsp_cycle, cap_cyc_count;

    // Per-cycle comparison of the 32-bit port against the expected timeline
    always @(negedge clk) begin
        int  c;
        bit  busy, bus_on, rsp_exp;
        if (chk_en && rst) begin
            c       = cyc_n;
            busy    = (c >= e_a) && (c < e_free);
            bus_on  = e_bus && (c >= e_a) && (c <= e_last);
            rsp_exp = (c == e_rsp);
            check("req_ready", req_ready, !busy);
            check("wb_cyc", wb_cyc_o, bus_on);
            check("wb_stb", wb_stb_o, bus_on);
            if (bus_on && wb_cyc_o) begin
                check("wb_adr", wb_adr_o, e_adr);
                check("wb_sel", wb_sel_o, e_sel);
                check("wb_we", wb_we_o, e_we);
                if (e_we) check("wb_dat", wb_dat_o, e_dat);
            end
            check("rsp_valid", rsp_valid, rsp_exp);
            if (rsp_exp && rsp_valid) begin
                check("rsp_rdata", rsp_rdata, e_rdata);
                check("rsp_err", rsp_err, e_err);
            end
            if (wb_cyc_o) begin
                cap_adr = wb_adr_o; cap_dat = wb_dat_o; cap_sel = wb_sel_o; cap_we = wb_we_o;
                cap_cyc_count++;
            end
            if (rsp_valid) begin
                cap_rdata = rsp_rdata; cap_err = rsp_err; cap_rsp_cycle = c;
            end
        end
    end

    always @(posedge clk) begin
        if (cyc_n > 50000) begin
            $display("FAIL watchdog cycles=%0d limit=50000", cyc_n);
            $fatal(1, "watchdog");
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic junk();
        wb_ack_i = 1'($urandom);
        wb_err_i = 1'($urandom);
        wb_dat_i = $urandom;
    endtask

    task automatic cap_clear();
        cap_rsp_cycle = -1; cap_cyc_count = 0;
        cap_adr = '0; cap_dat = '0; cap_sel = '0; cap_we = 1'b0; cap_rdata = '0; cap_err = '0;
    endtask

    task automatic txn(input logic [31:0] addr, input logic [31:0] wdata, input logic we,
                       input logic [1:0] size, input logic uns, input logic [31:0] bdata,
                       input int mode, input int w, input int kill_k);
        int a, kend;
        bit mis;
        step();
        while (cyc_n < e_free + 1) begin junk(); step(); end
        a   = cyc_n + 1;
        mis = m_mis(addr, size);
        e_a = a; e_adr = {addr[31:2], 2'b00}; e_sel = m_sel(addr, size);
        e_dat = m_dat(addr, wdata); e_we = we; e_rdata = '0;
        kend = w;
        if (mis) begin
            e_bus = 0; e_last = NONE; e_err = 2'd1; e_free = a + 1;
            e_rsp = (mode == M_KRESP) ? NONE : a + 1;
        end else begin
            e_bus = 1;
            case (mode)
                M_TMO: begin
                    kend = T - 1; e_last = a + T - 1; e_rsp = a + T + 1; e_free = a + T + 1; e_err = 2'd3;
                end
                M_KBUS: begin
                    kend = kill_k; e_last = a + kill_k; e_rsp = NONE; e_free = a + kill_k + 1;
                end
                default: begin
                    e_last = a + w; e_free = a + w + 2;
                    e_rsp  = (mode == M_KRESP) ? NONE : a + w + 2;
                    e_err  = (mode == M_ERR) ? 2'd2 : 2'd0;
                    if (mode != M_ERR && !we) e_rdata = m_load(addr, size, uns, bdata);
                end
            endcase
        end
        req_valid = 1'b1; req_addr = addr; req_wdata = wdata; req_we = we;
        req_size = size; req_unsigned = uns; kill = ($urandom % 4 == 0);
        junk();
        step();
        req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_size = 2'($urandom);
        kill = 1'b0;
        if (mis) begin
            kill = (mode == M_KRESP);
            junk();
            step();
            kill = 1'b0;
        end else begin
            for (int k = 0; k <= kend; k++) begin
                wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_dat_i = $urandom;
                if (k == kend) begin
                    case (mode)
                        M_ACK, M_KRESP: begin wb_ack_i = 1'b1; wb_dat_i = bdata; end
                        M_ERR:          wb_err_i = 1'b1;
                        M_BOTH:         begin wb_ack_i = 1'b1; wb_err_i = 1'b1; wb_dat_i = bdata; end
                        M_KBUS:         kill = 1'b1;
                        default:        ;
                    endcase
                end
                step();
                kill = 1'b0; wb_ack_i = 1'b0; wb_err_i = 1'b0;
            end
            if (mode == M_KRESP) begin
                kill = 1'b1; junk(); step(); kill = 1'b0;
            end
        end
        while (cyc_n <= e_free) begin junk(); step(); end
        junk();
    endtask

    task automatic h_txn(input logic [31:0] addr, input logic [63:0] wdata, input logic we,
                         input logic [1:0] size, input logic uns, input logic [63:0] bdata,
                         output logic [7:0] sel, output logic [31:0] adr, output logic [63:0] dat,
                         output logic [63:0] rdata, output logic [1:0] err, output int lat);
        int a;
        bit done;
        sel = '0; adr = '0; dat = '0; rdata = '0; err = '0; lat = -1; done = 0;
        step();
        h_req_valid = 1'b1; h_req_addr = addr; h_req_wdata = wdata; h_req_we = we;
        h_req_size = size; h_req_unsigned = uns;
        a = cyc_n + 1;
        step();
        h_req_valid = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            h_wb_ack_i = 1'b0;
            if (h_wb_cyc_o) begin
                sel = h_wb_sel_o; adr = h_wb_adr_o; dat = h_wb_dat_o;
                h_wb_ack_i = 1'b1; h_wb_dat_i = bdata;
            end
            if (h_rsp_valid) begin
                rdata = h_rsp_rdata; err = h_rsp_err; lat = cyc_n - a; done = 1;
            end
            step();
        end
        h_wb_ack_i = 1'b0;
        check("h_rsp_seen", done, 1'b1);
    endtask

    initial begin
        logic [7:0]  hs;
        logic [31:0] ha, ra, rw;
        logic [63:0] hd, hr;
        logic [1:0]  he, rs;
        int          hl, r, md;

        rst = 1'b0;
        req_valid = 0; req_addr = 0; req_wdata = 0; req_we = 0; req_size = 0; req_unsigned = 0; kill = 0;
        wb_dat_i = 0; wb_ack_i = 0; wb_err_i = 0;
        h_req_valid = 0; h_req_addr = 0; h_req_wdata = 0; h_req_we = 0; h_req_size = 0;
        h_req_unsigned = 0; h_kill = 0; h_wb_dat_i = 0; h_wb_ack_i = 0; h_wb_err_i = 0;
        cap_clear();
        step(); step();
        check("rst_ready", req_ready, 1'b0);
        check("rst_cyc", wb_cyc_o, 1'b0);
        check("rst_stb", wb_stb_o, 1'b0);
        check("rst_we", wb_we_o, 1'b0);
        check("rst_adr", wb_adr_o, 32'h0);
        check("rst_dat", wb_dat_o, 32'h0);
        check("rst_sel", wb_sel_o, 4'h0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_rsp_err", rsp_err, 2'd0);
        rst = 1'b1;
        chk_en = 1;

        cap_clear();
        txn(32'h1002, 32'h0, 1'b0, 2'd1, 1'b0, 32'h8001_1234, M_ACK, 2, 0);
        check("d1_sel", cap_sel, 4'hC);
        check("d1_adr", cap_adr, 32'h1000);
        check("d1_rdata", cap_rdata, 32'hFFFF_8001);
        check("d1_err", cap_err, 2'd0);
        check("d1_latency", cap_rsp_cycle - e_a, 4);

        cap_clear();
        txn(32'h2003, 32'hA5, 1'b1, 2'd0, 1'b0, 32'h0, M_ACK, 0, 0);
        check("d2_sel", cap_sel, 4'h8);
        check("d2_dat", cap_dat[31:24], 8'hA5);
        check("d2_we", cap_we, 1'b1);
        check("d2_err", cap_err, 2'd0);
        check("d2_latency", cap_rsp_cycle - e_a, 2);

        cap_clear();
        txn(32'h3001, 32'h0, 1'b0, 2'd2, 1'b0, 32'h0, M_ACK, 0, 0);
        check("d3_cyc_count", cap_cyc_count, 0);
        check("d3_latency", cap_rsp_cycle - e_a, 1);
        check("d3_err", cap_err, 2'd1);

        cap_clear();
        txn(32'h5000, 32'h0, 1'b0, 2'd2, 1'b0, 32'h0, M_TMO, 0, 0);
        check("d4_cyc_count", cap_cyc_count, 8);
        check("d4_err", cap_err, 2'd3);

        cap_clear();
        txn(32'h5004, 32'h0, 1'b0, 2'd2, 1'b0, 32'h0, M_ERR, 1, 0);
        check("d5_err", cap_err, 2'd2);
        check("d5_rdata", cap_rdata, 32'h0);

        cap_clear();
        txn(32'h6000, 32'h0, 1'b0, 2'd2, 1'b0, 32'h0, M_KBUS, 0, 2);
        check("d6_cyc_count", cap_cyc_count, 3);
        check("d6_no_rsp", cap_rsp_cycle, -1);

        // Reset pulled in the middle of a bus cycle
        step();
        chk_en = 0;
        req_valid = 1'b1; req_addr = 32'h7000; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
        wb_ack_i = 1'b0; wb_err_i = 1'b0;
        step();
        req_valid = 1'b0;
        step(); step();
        check("d7_cyc_mid", wb_cyc_o, 1'b1);
        rst = 1'b0;
        #1;
        check("d7_rst_cyc", wb_cyc_o, 1'b0);
        check("d7_rst_ready", req_ready, 1'b0);
        check("d7_rst_rsp", rsp_valid, 1'b0);
        junk(); step();
        check("d7_rst_rsp2", rsp_valid, 1'b0);
        rst = 1'b1;
        wb_ack_i = 1'b1; wb_err_i = 1'b1;
        step();
        check("d7_ready_back", req_ready, 1'b1);
        check("d7_cyc_idle", wb_cyc_o, 1'b0);
        check("d7_rsp_idle", rsp_valid, 1'b0);
        e_a = NONE; e_last = NONE; e_rsp = NONE; e_free = NONE; e_bus = 0;
        chk_en = 1;

        for (int n = 0; n < 200; n++) begin
            ra = $urandom;
            rs = 2'($urandom);
            rw = $urandom;
            if ($urandom % 4 != 0 && rs != 2'd3) ra[1:0] = ra[1:0] & ~2'((1 << rs) - 1);
            r = $urandom % 100;
            md = (r < 45) ? M_ACK : (r < 60) ? M_ERR : (r < 70) ? M_BOTH :
                 (r < 75) ? M_TMO : (r < 90) ? M_KBUS : M_KRESP;
            txn(ra, rw, 1'($urandom), rs, 1'($urandom), $urandom, md, $urandom % 4, $urandom % 4);
        end

        h_txn(32'h4004, 64'h0, 1'b0, 2'd2, 1'b1, 64'h9000_0001_1234_5678, hs, ha, hd, hr, he, hl);
        check("h1_sel", hs, 8'hF0);
        check("h1_adr", ha, 32'h4000);
        check("h1_rdata", hr, 64'h0000_0000_9000_0001);
        check("h1_err", he, 2'd0);
        check("h1_latency", hl, 2);
        h_txn(32'h4000, 64'h0, 1'b0, 2'd2, 1'b0, 64'h1111_2222_8000_0000, hs, ha, hd, hr, he, hl);
        check("h2_rdata", hr, 64'hFFFF_FFFF_8000_0000);
        h_txn(32'h4008, 64'h0, 1'b0, 2'd3, 1'b0, 64'hDEAD_BEEF_0123_4567, hs, ha, hd, hr, he, hl);
        check("h3_sel", hs, 8'hFF);
        check("h3_adr", ha, 32'h4008);
        check("h3_rdata", hr, 64'hDEAD_BEEF_0123_4567);
        h_txn(32'h400E, 64'hBEEF, 1'b1, 2'd1, 1'b0, 64'h0, hs, ha, hd, hr, he, hl);
        check("h4_sel", hs, 8'hC0);
        check("h4_dat", hd, 64'hBEEF_0000_0000_0000);
        check("h4_rdata", hr, 64'h0);
        h_txn(32'h4004, 64'h0, 1'b0, 2'd3, 1'b0, 64'h0, hs, ha, hd, hr, he, hl);
        check("h5_err", he, 2'd1);
        check("h5_latency", hl, 1);
        check("h5_no_bus", hs, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
